alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Purpose: sequences one ALU operation per request through save/load/exec/wait/restore strobes and reports result flags/acc.
// Latency: accept-to-done is 4 edges for non-preserve ops with operand load, 3 without load, 1 for illegal opcodes (+2 with preserve).
// Backpressure: single pending slot; req_ready = !pending_full, so a new request is taken in any state once the slot drains.
// Optional feature macro: ALU_SEQ_PRESERVE_EN (honour req_preserve: save accumulator before, restore after).
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_op,
    input  logic [7:0] req_operand,
    input  logic       req_preserve,
    output logic [4:0] alu_opcode,
    output logic [7:0] alu_data,
    output logic       alu_ctrl_sig,
    output logic       alu_tmp_write_en,
    output logic       alu_act_store,
    output logic       alu_act_restore,
    input  logic [3:0] alu_flags_in,
    input  logic [7:0] alu_acc_in,
    output logic       done,
    output logic       err,
    output logic [3:0] res_flags,
    output logic [7:0] res_acc
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SAVE    = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_RESTORE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

`ifdef ALU_SEQ_PRESERVE_EN
    localparam logic PRES_EN = 1'b1;
`else
    localparam logic PRES_EN = 1'b0;
`endif

    // DAA and everything above DCR have no ALU meaning.
    function automatic logic op_illegal(input logic [4:0] op);
        return (op == 5'b01100) || (op >= 5'b10010);
    endfunction

    // Opcodes below 01000 take a second operand through the tmp register.
    function automatic logic op_needs_load(input logic [4:0] op);
        return op < 5'b01000;
    endfunction

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       pend_full;
    logic [4:0] pend_op;
    logic [7:0] pend_operand;
    logic       pend_pres;
    logic [4:0] work_op;
    logic [7:0] work_operand;
    logic       work_pres;
    logic       accept;
    logic       take;

    assign req_ready = !pend_full;
    assign accept    = req_valid && !pend_full;
    assign take      = (state == S_IDLE) && pend_full;

    // Pending slot: filled on accept, drained when IDLE hands it to the working register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full    <= 1'b0;
            pend_op      <= 5'd0;
            pend_operand <= 8'd0;
            pend_pres    <= 1'b0;
        end else if (take) begin
            pend_full <= 1'b0;
        end else if (accept) begin
            pend_full    <= 1'b1;
            pend_op      <= req_op;
            pend_operand <= req_operand;
            pend_pres    <= req_preserve & PRES_EN;
        end
    end

    // Working register drives the ALU opcode/data buses for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_op      <= 5'd0;
            work_operand <= 8'd0;
            work_pres    <= 1'b0;
        end else if (take) begin
            work_op      <= pend_op;
            work_operand <= pend_operand;
            work_pres    <= pend_pres;
        end
    end

    // Next-state selection; preserve states are only entered when the feature is built in.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pend_full) begin
                    if (op_illegal(pend_op))          state_nxt = S_DONE;
                    else if (pend_pres)               state_nxt = S_SAVE;
                    else if (op_needs_load(pend_op))  state_nxt = S_LOAD;
                    else                              state_nxt = S_EXEC;
                end
            end
            S_SAVE:    state_nxt = op_needs_load(work_op) ? S_LOAD : S_EXEC;
            S_LOAD:    state_nxt = S_EXEC;
            S_EXEC:    state_nxt = S_WAIT;
            S_WAIT:    state_nxt = work_pres ? S_RESTORE : S_DONE;
            S_RESTORE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Results captured leaving WAIT, before any restore disturbs the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_flags <= 4'd0;
            res_acc   <= 8'd0;
        end else if (state == S_WAIT) begin
            res_flags <= alu_flags_in;
            res_acc   <= alu_acc_in;
        end
    end

    assign alu_opcode       = work_op;
    assign alu_data         = work_operand;
    assign alu_tmp_write_en = (state == S_LOAD);
    assign alu_ctrl_sig     = (state == S_EXEC);
`ifdef ALU_SEQ_PRESERVE_EN
    assign alu_act_store    = (state == S_SAVE);
    assign alu_act_restore  = (state == S_RESTORE);
`else
    assign alu_act_store    = 1'b0;
    assign alu_act_restore  = 1'b0;
`endif
    assign done = (state == S_DONE);
    assign err  = (state == S_DONE) && op_illegal(work_op);

endmodule
